// File: rtl/sdr_host_arbiter_pkg.sv
// Shared constants and state encoding for the two-host SDRAM request arbiter.
package sdr_host_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 23;
  localparam int TIMEOUT_DEF    = 1023;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_e;

  // One-hot pulse vector for a single host index.
  function automatic logic [1:0] host_onehot(input logic host);
    return host ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdr_rr_pick.sv
// Two-request round-robin picker: combinational winner, registered priority pointer.
module sdr_rr_pick (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_val_i,
  output logic       winner_o,
  output logic       any_o
);

  logic ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   ptr_q <= 1'b0;
    else if (upd_i) ptr_q <= upd_val_i;
  end

  assign any_o    = |req_i;
  // The pointer only matters on a tie; a lone request always wins.
  assign winner_o = (&req_i) ? ptr_q : req_i[1];

endmodule

// File: rtl/sdr_host_arbiter.sv
// Round-robin arbiter feeding one command/write-data bundle to the SDRAM controller.
// Optional read-wait watchdog enabled with `define SDR_ARB_TIMEOUT_EN.
//
//   state      | meaning
//   IDLE       | no command outstanding, arbitrate on REQ0/REQ1
//   ISSUE      | command presented, waiting for CMD_ACK
//   RD_WAIT    | read accepted, waiting for RD_VALID_IN (or watchdog)
module sdr_host_arbiter
  import sdr_host_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic                    WR0,
  input  logic                    WR1,
  input  logic [ADDR_WIDTH-1:0]   ADDR0,
  input  logic [ADDR_WIDTH-1:0]   ADDR1,
  input  logic [DATA_WIDTH-1:0]   WDATA0,
  input  logic [DATA_WIDTH-1:0]   WDATA1,
  input  logic [DATA_WIDTH/8-1:0] DM0,
  input  logic [DATA_WIDTH/8-1:0] DM1,
  output logic                    GNT0,
  output logic                    GNT1,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    RVALID0,
  output logic                    RVALID1,
  output logic                    CMD_VALID,
  output logic                    CMD_WR,
  output logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  output logic [DATA_WIDTH-1:0]   DATAOUT,
  output logic [DATA_WIDTH/8-1:0] DMOUT,
  input  logic                    CMD_ACK,
  input  logic                    RD_VALID_IN,
  input  logic [DATA_WIDTH-1:0]   RD_DATA_IN,
  output logic                    TIMEOUT_ERR
);

  localparam int MW = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
  logic [MW-1:0]         dmout_q, dmout_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  winner, any_req, ptr_upd;
  logic                  rd_timeout;

  sdr_rr_pick u_pick (
    .clk_i    (CLK),
    .rst_n_i  (RESET_N),
    .req_i    ({REQ1, REQ0}),
    .upd_i    (ptr_upd),
    .upd_val_i(~owner_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

`ifdef SDR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;
  logic          timeout_err_q;

  // Counter sits at zero outside RD_WAIT, so it starts from zero on entry.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= (state_q == ST_RD_WAIT && !rd_timeout) ? to_cnt_q + 1'b1 : '0;
      timeout_err_q <= timeout_err_q | rd_timeout;
    end
  end

  assign rd_timeout  = (state_q == ST_RD_WAIT) && !RD_VALID_IN &&
                       (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_ERR = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rd_timeout     = 1'b0;
  assign TIMEOUT_ERR    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      dataout_q   <= '0;
      dmout_q     <= '1;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      dataout_q   <= dataout_d;
      dmout_q     <= dmout_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (any_req) state_d = ST_ISSUE;
      ST_ISSUE:   if (CMD_ACK) state_d = cmd_wr_q ? ST_IDLE : ST_RD_WAIT;
      ST_RD_WAIT: if (RD_VALID_IN || rd_timeout) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    dataout_d   = dataout_q;
    dmout_d     = dmout_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    ptr_upd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = winner ? WR1    : WR0;
          cmd_addr_d  = winner ? ADDR1  : ADDR0;
          dataout_d   = winner ? WDATA1 : WDATA0;
          dmout_d     = winner ? DM1    : DM0;
        end
      end
      ST_ISSUE: begin
        if (CMD_ACK) begin
          cmd_valid_d = 1'b0;
          dmout_d     = '1;
          gnt_d       = host_onehot(owner_q);
          ptr_upd     = cmd_wr_q;
        end
      end
      ST_RD_WAIT: begin
        if (RD_VALID_IN) begin
          rdata_d  = RD_DATA_IN;
          rvalid_d = host_onehot(owner_q);
          ptr_upd  = 1'b1;
        end else if (rd_timeout) begin
          rdata_d  = '0;
          rvalid_d = host_onehot(owner_q);
          ptr_upd  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign CMD_VALID = cmd_valid_q;
  assign CMD_WR    = cmd_wr_q;
  assign CMD_ADDR  = cmd_addr_q;
  assign DATAOUT   = dataout_q;
  assign DMOUT     = dmout_q;
  assign GNT0      = gnt_q[0];
  assign GNT1      = gnt_q[1];
  assign RVALID0   = rvalid_q[0];
  assign RVALID1   = rvalid_q[1];
  assign RDATA     = rdata_q;

endmodule
